// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width,
// kernel geometry, tap indices (row-major, NW first) and FSM states.
package conv_pkg;

  localparam int PIX_W_DEFAULT = 8;
  localparam int KERNEL_SIZE   = 3;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: circular single-port RAM with an asynchronous
// read and a synchronous write, so a read and write to the same address in
// one cycle return the old contents (read-before-write).
module conv_line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // write the incoming pixel after the old one has been read out
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator. Two line buffers hold rows y-1 and y; the
// incoming pixel completes a fresh column that is shifted into two column
// registers, so the window centred one row up and one column left is ready
// combinationally and registered onto win_data on the same accept.
// Build option: define CONV_WIN_REPLICATE_EN to clamp border taps to the
// nearest in-image pixel instead of zero padding; timing is unchanged.
//
// state  | meaning
// FILL   | accept the first W+1 pixels of a frame, no windows yet
// STREAM | each accepted pixel emits one window
// FLUSH  | no input; emit the last W+1 windows, then pulse frame_done
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 256,
  parameter int IMAGE_HEIGHT = 256,
  parameter int PIX_W        = PIX_W_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PIX_W-1:0]                      pix_data,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0] win_data,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic [$clog2(IMAGE_WIDTH)-1:0]        win_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]       win_y,
  output logic                                  win_last,
  output logic                                  frame_done
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMAGE_HEIGHT - 1);

  conv_state_t state, state_nxt;
  logic run;
  logic [XW-1:0] in_x, out_x;
  logic [YW-1:0] in_y, out_y;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] col0 [KERNEL_SIZE];
  logic [PIX_W-1:0] col1 [KERNEL_SIZE];
  logic [PIX_W-1:0] col_new [KERNEL_SIZE];
  logic [PIX_W-1:0] raw [KERNEL_SIZE*KERNEL_SIZE];
  logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0] win_nxt;
  logic out_free, pix_acc, gen, frame_end, adv_in;
  logic at_top, at_bot, at_left, at_right;

  // run holds pix_ready low until the first clock after reset release
  assign out_free   = !win_valid || win_ready;
  assign pix_ready  = run && ((state == ST_FILL) || (state == ST_STREAM && out_free));
  assign pix_acc    = pix_valid && pix_ready;
  assign frame_end  = (state == ST_FLUSH) && win_valid && win_ready && win_last;
  assign frame_done = frame_end;
  assign adv_in     = pix_acc || (state == ST_FLUSH && gen);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // next state and window-generate strobe
  always_comb begin
    state_nxt = state;
    gen       = 1'b0;
    case (state)
      ST_FILL: begin
        if (pix_acc && in_x == '0 && in_y == YW'(1)) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        gen = pix_acc;
        if (pix_acc && in_x == X_MAX && in_y == Y_MAX) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        gen = out_free && !(win_valid && win_last);
        if (frame_end) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // input position keeps advancing through FLUSH to address the line buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_x  <= '0;
      in_y  <= '0;
      out_x <= '0;
      out_y <= '0;
    end else if (frame_end) begin
      in_x  <= '0;
      in_y  <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (adv_in) begin
        in_x <= (in_x == X_MAX) ? '0 : in_x + 1'b1;
        if (pix_acc && in_x == X_MAX) in_y <= (in_y == Y_MAX) ? '0 : in_y + 1'b1;
      end
      if (gen) begin
        out_x <= (out_x == X_MAX) ? '0 : out_x + 1'b1;
        if (out_x == X_MAX) out_y <= (out_y == Y_MAX) ? '0 : out_y + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk), .addr(in_x), .wr_en(pix_acc), .wr_data(pix_data), .rd_data(lb0_rd)
  );

  conv_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .addr(in_x), .wr_en(pix_acc), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  // newest column, top to bottom; the bottom tap during FLUSH is below the image
  assign col_new[0] = lb1_rd;
  assign col_new[1] = lb0_rd;
  assign col_new[2] = pix_acc ? pix_data : '0;

  // column shift registers feeding the left and centre window columns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col0 <= '{default: '0};
      col1 <= '{default: '0};
    end else if (pix_acc || gen) begin
      col0 <= col1;
      col1 <= col_new;
    end
  end

  // unpadded neighbourhood in tap order
  always_comb begin
    raw[TAP_NW] = col0[0];
    raw[TAP_N]  = col1[0];
    raw[TAP_NE] = col_new[0];
    raw[TAP_W]  = col0[1];
    raw[TAP_C]  = col1[1];
    raw[TAP_E]  = col_new[1];
    raw[TAP_SW] = col0[2];
    raw[TAP_S]  = col1[2];
    raw[TAP_SE] = col_new[2];
  end

  assign at_top   = (out_y == '0);
  assign at_bot   = (out_y == Y_MAX);
  assign at_left  = (out_x == '0);
  assign at_right = (out_x == X_MAX);

`ifdef CONV_WIN_REPLICATE_EN
  int ri, ci;

  // clamp out-of-image taps onto the centre row/column
  always_comb begin
    win_nxt = '0;
    ri = 0;
    ci = 0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        ri = ((i == 0 && at_top) || (i == 2 && at_bot)) ? 1 : i;
        ci = ((j == 0 && at_left) || (j == 2 && at_right)) ? 1 : j;
        win_nxt[(i*KERNEL_SIZE+j)*PIX_W +: PIX_W] = raw[ri*KERNEL_SIZE+ci];
      end
    end
  end
`else
  // zero out-of-image taps; stale data from other lines/frames never leaks
  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        if (!((i == 0 && at_top) || (i == 2 && at_bot) ||
              (j == 0 && at_left) || (j == 2 && at_right)))
          win_nxt[(i*KERNEL_SIZE+j)*PIX_W +: PIX_W] = raw[i*KERNEL_SIZE+j];
      end
    end
  end
`endif

  // output register; only loaded when the slot is free, so stalls hold it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_x     <= '0;
      win_y     <= '0;
      win_last  <= 1'b0;
    end else if (gen) begin
      win_valid <= 1'b1;
      win_data  <= win_nxt;
      win_x     <= out_x;
      win_y     <= out_y;
      win_last  <= at_right && at_bot;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule
